pulse_shaper_width: RTL and testbench
=====================================

// Module: pulse_shaper_width
// PURPOSE
//  Per-channel pulse former ahead of the coincidence logic. Turns each rising edge of a raw
//  discriminator input into one output pulse of exactly WIDTH clocks, then enforces DEAD clocks
//  of dead time. This makes the pulse width deterministic for overlap tests downstream.
//  Counts accepted and rejected edges for rate and dead-time monitoring.
// PARAMETERS
//  WIDTH   40  output pulse length in clk cycles; legal range >= 1 (40 = 100 ns at 400 MHz)
//  DEAD    80  dead time after pulse end, in clk cycles; legal range >= 0 (0 = no dead time)
//  RETRIG  0   1: an edge during HIGH reloads the width counter; 0: the edge is rejected
//  CW      32  width of the accepted/rejected counters
// PORTS
//  clk      in   1   system clock; all logic on the rising edge
//  rst      in   1   synchronous reset, active-high
//  in       in   1   raw asynchronous discriminator input
//  clr_cnt  in   1   synchronous clear of both counters
//  out      out  1   shaped pulse, registered
//  busy     out  1   high in HIGH or DEAD state, registered
//  acc_cnt  out  CW  number of edges that started or retriggered a pulse; saturates at all-ones
//  rej_cnt  out  CW  number of edges ignored because of state; saturates at all-ones
// BEHAVIOUR
//  Input path: in -> 2-flop synchronizer -> in_s. A third flop holds in_d.
//  edge = in_s & ~in_d (single cycle).
//  Reset: state=IDLE, out=0, busy=0, acc_cnt=0, rej_cnt=0, counters cleared, sync flops=0,
//   in_d=1. An input already high when reset is released produces no edge until it falls.
//   Reset mid-pulse drops out on the next edge. Reset has priority over everything else.
//  States (one-hot or encoded, implementer's choice):
//   IDLE: edge -> HIGH, wcnt=WIDTH-1, acc+1.
//   HIGH: if wcnt==0: go to DEAD with dcnt=DEAD-1, or to IDLE if DEAD==0.
//         Otherwise wcnt-1.
//         Edge in HIGH, RETRIG=1: wcnt=WIDTH-1, acc+1. This takes priority over expiry in the same cycle.
//         Edge in HIGH, RETRIG=0: rej+1, no effect on timing.
//   DEAD: if dcnt==0 -> IDLE, else dcnt-1. Any edge in DEAD -> rej+1.
//         An edge in the same cycle as DEAD expiry is rejected. It is not queued.
//  out = registered (next_state==HIGH); busy = registered (next_state!=IDLE).
//   Latency: in rises before clk edge k, so in_s is high after k+1 and edge is seen at k+2.
//   out is high after edge k+2, giving 3 cycles latency.
//  Pulse timing: out stays high exactly WIDTH cycles (no retrigger), then busy alone stays high
//   DEAD cycles. Minimum edge-to-edge acceptance spacing = WIDTH+DEAD+1 cycles.
//   Accept the following edge when detected in the first IDLE cycle.
//  Counters: wcnt is $clog2(WIDTH+1) bits; dcnt is $clog2(DEAD+1) bits (min 1).
//   acc/rej saturate, no wrap. clr_cnt in the same cycle as an increment: clear wins, result 0.
//  Input pulse shorter than one clk may be missed; that is accepted by design.
//  Input held high produces one edge only.
// TESTING
//  1 rst 3 cycles, in held 1 across release -> out stays 0, acc=0; in 0 then 1 -> single pulse, acc=1
//  2 WIDTH=4 DEAD=6: 1-cycle in pulse -> out high exactly 4 cycles at latency 3; busy high 10 cycles
//  3 WIDTH=4 DEAD=6 RETRIG=0: edges 2 and 8 cycles after first -> both rej; 11 cycles after -> acc
//  4 RETRIG=1 WIDTH=4: edge at pulse cycle 3 -> out high 3+4=7 cycles total; acc=2, rej=0
//  5 CW=4: 20 accepted edges -> acc_cnt=15 held; clr_cnt with an edge in the same cycle -> acc=0
//  6 rst asserted during HIGH -> out=0, busy=0 next cycle; the first edge after release is accepted normally

Source files
------------

// File: rtl/pulse_shaper_width.sv
// Per-channel pulse former: each synchronized rising edge of `in` yields one WIDTH-cycle pulse
// followed by DEAD cycles of dead time, with saturating accepted/rejected edge counters.
module pulse_shaper_width #(
  parameter int WIDTH  = 40,
  parameter int DEAD   = 80,
  parameter int RETRIG = 0,
  parameter int CW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in,
  input  logic          clr_cnt,
  output logic          out,
  output logic          busy,
  output logic [CW-1:0] acc_cnt,
  output logic [CW-1:0] rej_cnt
);

  localparam int WW = $clog2(WIDTH + 1);
  localparam int DW = (DEAD < 1) ? 1 : $clog2(DEAD + 1);
  localparam logic [WW-1:0] W_LOAD = WW'(WIDTH - 1);
  localparam logic [DW-1:0] D_LOAD = DW'((DEAD > 0) ? DEAD - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_DEAD} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            in_s_q, in_s_d;
  logic            in_d_q, in_d_d;
  logic [1:0]      prime_q, prime_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            out_q, out_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   rej_q, rej_d;
  logic            edge_det;
  logic            acc_inc;
  logic            rej_inc;

  always_comb begin
    sync1_d  = in;
    in_s_d   = sync1_q;
    // in_d is held high until the synchronizer has been refilled with real samples, so an
    // input already high at reset release cannot fake an edge from the zeroed sync flops.
    prime_d  = {prime_q[0], 1'b1};
    in_d_d   = prime_q[1] ? in_s_q : 1'b1;
    edge_det = in_s_q & ~in_d_q;

    state_d  = state_q;
    wcnt_d   = wcnt_q;
    dcnt_d   = dcnt_q;
    acc_inc  = 1'b0;
    rej_inc  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (edge_det) begin
          state_d = ST_HIGH;
          wcnt_d  = W_LOAD;
          acc_inc = 1'b1;
        end
      end
      ST_HIGH: begin
        if (edge_det && (RETRIG != 0)) begin
          wcnt_d  = W_LOAD;
          acc_inc = 1'b1;
        end else begin
          rej_inc = edge_det;
          if (wcnt_q == '0) begin
            if (DEAD == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DEAD;
              dcnt_d  = D_LOAD;
            end
          end else begin
            wcnt_d = wcnt_q - WW'(1);
          end
        end
      end
      ST_DEAD: begin
        rej_inc = edge_det;
        if (dcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);

    acc_d = acc_q;
    rej_d = rej_q;
    if (acc_inc && (acc_q != '1)) acc_d = acc_q + CW'(1);
    if (rej_inc && (rej_q != '1)) rej_d = rej_q + CW'(1);
    if (clr_cnt) begin
      acc_d = '0;
      rej_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sync1_q <= 1'b0;
      in_s_q  <= 1'b0;
      in_d_q  <= 1'b1;
      prime_q <= 2'b00;
      wcnt_q  <= '0;
      dcnt_q  <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      acc_q   <= '0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      in_s_q  <= in_s_d;
      in_d_q  <= in_d_d;
      prime_q <= prime_d;
      wcnt_q  <= wcnt_d;
      dcnt_q  <= dcnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      acc_q   <= acc_d;
      rej_q   <= rej_d;
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign acc_cnt = acc_q;
  assign rej_cnt = rej_q;

endmodule

// File: tb/tb_pulse_shaper_width.sv
// Bench for pulse_shaper_width: three parameterisations driven by shared stimulus, checked by
// directed vector tables, hand-written corner sequences and a timestamp-based reference model.
module tb_pulse_shaper_width;

  localparam int CW_C = 4;

  logic clk = 1'b0;
  logic rst, in_sig, clr_cnt;
  logic out_a, busy_a, out_b, busy_b, out_c, busy_c;
  logic [31:0] acc_a, rej_a, acc_b, rej_b;
  logic [CW_C-1:0] acc_c, rej_c;

  always #5 clk = ~clk;

  pulse_shaper_width #(.WIDTH(4), .DEAD(6), .RETRIG(0), .CW(32)) dut_a (
    .clk(clk), .rst(rst), .in(in_sig), .clr_cnt(clr_cnt),
    .out(out_a), .busy(busy_a), .acc_cnt(acc_a), .rej_cnt(rej_a));

  pulse_shaper_width #(.WIDTH(4), .DEAD(6), .RETRIG(1), .CW(32)) dut_b (
    .clk(clk), .rst(rst), .in(in_sig), .clr_cnt(clr_cnt),
    .out(out_b), .busy(busy_b), .acc_cnt(acc_b), .rej_cnt(rej_b));

  pulse_shaper_width #(.WIDTH(3), .DEAD(0), .RETRIG(0), .CW(CW_C)) dut_c (
    .clk(clk), .rst(rst), .in(in_sig), .clr_cnt(clr_cnt),
    .out(out_c), .busy(busy_c), .acc_cnt(acc_c), .rej_cnt(rej_c));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each channel is described by the last cycle its output/busy is high,
  // and an edge is the sampled input rising, seen two cycles after the sample.
  longint cyc = 0;
  longint last_rst = 0;
  bit     hist[4];
  int     m_w[3], m_d[3];
  bit     m_rt[3];
  longint m_max[3];
  longint out_last[3], busy_last[3], m_acc[3], m_rej[3];

  function automatic longint act_val(int i, int sel);
    logic o, b;
    longint a, r;
    case (i)
      0: begin o = out_a; b = busy_a; a = longint'(acc_a); r = longint'(rej_a); end
      1: begin o = out_b; b = busy_b; a = longint'(acc_b); r = longint'(rej_b); end
      default: begin o = out_c; b = busy_c; a = longint'(acc_c); r = longint'(rej_c); end
    endcase
    case (sel)
      0: return longint'(o);
      1: return longint'(b);
      2: return a;
      default: return r;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_update(input bit iv, input bit rv, input bit cv);
    bit e;
    cyc++;
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = iv;
    if (rv) begin
      last_rst = cyc;
      for (int i = 0; i < 3; i++) begin
        out_last[i] = -100; busy_last[i] = -100; m_acc[i] = 0; m_rej[i] = 0;
      end
    end else begin
      e = hist[2] && !hist[3] && (cyc - 3 >= last_rst + 1);
      for (int i = 0; i < 3; i++) begin
        if (e) begin
          if ((cyc - 1 > busy_last[i]) || (m_rt[i] && (cyc - 1 <= out_last[i]))) begin
            out_last[i]  = cyc + m_w[i] - 1;
            busy_last[i] = cyc + m_w[i] + m_d[i] - 1;
            if (m_acc[i] < m_max[i]) m_acc[i]++;
          end else if (m_rej[i] < m_max[i]) begin
            m_rej[i]++;
          end
        end
        if (cv) begin
          m_acc[i] = 0; m_rej[i] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic iv, input logic rv, input logic cv);
    in_sig = iv; rst = rv; clr_cnt = cv;
    @(posedge clk);
    model_update(iv, rv, cv);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_out%0d", i),  act_val(i, 0), longint'(cyc <= out_last[i]));
      chk($sformatf("model_busy%0d", i), act_val(i, 1), longint'(cyc <= busy_last[i]));
      chk($sformatf("model_acc%0d", i),  act_val(i, 2), m_acc[i]);
      chk($sformatf("model_rej%0d", i),  act_val(i, 3), m_rej[i]);
    end
  endtask

  typedef struct {
    logic iv, rv, cv;
    int   ncyc;
    logic e_out, e_busy;
    int   e_acc, e_rej;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, rv, cv, input int n, input logic eo, eb, input int ea, er);
    vec_t v;
    v.iv = iv; v.rv = rv; v.cv = cv; v.ncyc = n;
    v.e_out = eo; v.e_busy = eb; v.e_acc = ea; v.e_rej = er;
    vecs.push_back(v);
  endtask

  initial begin
    int outs;
    longint a0, r0;
    int runlen, maxlen;
    logic cur;
    int lens[4];

    m_w  = '{4, 4, 3};
    m_d  = '{6, 6, 0};
    m_rt = '{1'b0, 1'b1, 1'b0};
    m_max = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    for (int i = 0; i < 4; i++) hist[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      out_last[i] = -100; busy_last[i] = -100; m_acc[i] = 0; m_rej[i] = 0;
    end
    rst = 1'b1; in_sig = 1'b0; clr_cnt = 1'b0;

    // Expectations below are for dut_a (WIDTH=4, DEAD=6, RETRIG=0), checked on each row's last cycle.
    add(1, 1, 0, 3,  0, 0, 0, 0);   // reset with input high
    add(1, 0, 0, 8,  0, 0, 0, 0);   // held high across release: no edge
    add(0, 0, 0, 3,  0, 0, 0, 0);
    add(1, 0, 0, 1,  0, 0, 0, 0);   // one-cycle input pulse
    add(0, 0, 0, 1,  0, 0, 0, 0);
    add(0, 0, 0, 1,  1, 1, 1, 0);   // latency 3
    add(0, 0, 0, 3,  1, 1, 1, 0);   // 4th high cycle
    add(0, 0, 0, 1,  0, 1, 1, 0);
    add(0, 0, 0, 5,  0, 1, 1, 0);   // 10th busy cycle
    add(0, 0, 0, 1,  0, 0, 1, 0);
    add(1, 0, 0, 1,  0, 0, 1, 0);   // first edge of spacing test
    add(0, 0, 0, 1,  0, 0, 1, 0);
    add(1, 0, 0, 1,  1, 1, 2, 0);
    add(0, 0, 0, 5,  0, 1, 2, 1);   // +2 edge rejected in HIGH
    add(1, 0, 0, 1,  0, 1, 2, 1);
    add(0, 0, 0, 2,  0, 1, 2, 2);   // +8 edge rejected in DEAD
    add(1, 0, 0, 1,  0, 1, 2, 2);
    add(0, 0, 0, 1,  0, 0, 2, 2);
    add(0, 0, 0, 1,  1, 1, 3, 2);   // +11 edge accepted in first IDLE cycle
    add(0, 0, 0, 12, 0, 0, 3, 2);
    add(1, 0, 0, 1,  0, 0, 3, 2);
    add(0, 0, 0, 1,  0, 0, 3, 2);
    add(0, 0, 1, 1,  1, 1, 0, 0);   // clear wins over same-cycle accept
    add(0, 0, 0, 12, 0, 0, 0, 0);
    add(1, 0, 0, 1,  0, 0, 0, 0);
    add(0, 0, 0, 3,  1, 1, 1, 0);
    add(0, 1, 0, 1,  0, 0, 0, 0);   // reset mid-pulse
    add(0, 0, 0, 3,  0, 0, 0, 0);
    add(1, 0, 0, 1,  0, 0, 0, 0);
    add(0, 0, 0, 2,  1, 1, 1, 0);   // first edge after reset accepted
    add(0, 0, 0, 12, 0, 0, 1, 0);

    foreach (vecs[k]) begin
      for (int c = 0; c < vecs[k].ncyc; c++) step(vecs[k].iv, vecs[k].rv, vecs[k].cv);
      chk($sformatf("row%0d_out", k),  longint'(out_a),  longint'(vecs[k].e_out));
      chk($sformatf("row%0d_busy", k), longint'(busy_a), longint'(vecs[k].e_busy));
      chk($sformatf("row%0d_acc", k),  longint'(acc_a),  longint'(vecs[k].e_acc));
      chk($sformatf("row%0d_rej", k),  longint'(rej_a),  longint'(vecs[k].e_rej));
      $display("row %0d: in=%0b rst=%0b clr=%0b x%0d -> out=%0b busy=%0b acc=%0d rej=%0d",
               k, vecs[k].iv, vecs[k].rv, vecs[k].cv, vecs[k].ncyc, out_a, busy_a, acc_a, rej_a);
    end

    // Retrigger on the third high cycle of dut_b stretches its pulse to 3+4 cycles.
    a0 = longint'(acc_b); r0 = longint'(rej_b); outs = 0;
    step(1, 0, 0); outs += int'(out_b);
    step(0, 0, 0); outs += int'(out_b);
    step(0, 0, 0); outs += int'(out_b);
    step(1, 0, 0); outs += int'(out_b);
    for (int c = 0; c < 20; c++) begin
      step(0, 0, 0); outs += int'(out_b);
    end
    chk("retrig_out_len", longint'(outs), 7);
    chk("retrig_acc_delta", longint'(acc_b) - a0, 2);
    chk("retrig_rej_delta", longint'(rej_b) - r0, 0);
    $display("retrigger: out_b high %0d cycles, acc_b +%0d", outs, longint'(acc_b) - a0);

    // Saturation of the 4-bit counter on dut_c, then clear racing an accept.
    step(0, 0, 1);
    for (int p = 0; p < 20; p++) begin
      step(1, 0, 0);
      for (int c = 0; c < 5; c++) step(0, 0, 0);
    end
    chk("sat_acc_c", longint'(acc_c), 15);
    chk("sat_rej_c", longint'(rej_c), 0);
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 1);
    chk("sat_clr_acc_c", longint'(acc_c), 0);
    chk("sat_clr_out_c", longint'(out_c), 1);
    $display("saturation: acc_c after clear = %0d", acc_c);
    for (int c = 0; c < 12; c++) step(0, 0, 0);

    // Random run lengths of varying density against the reference model.
    lens = '{1, 3, 8, 20};
    cur = 1'b0;
    for (int blk = 0; blk < 30; blk++) begin
      maxlen = lens[$urandom_range(3)];
      for (int c = 0; c < 100; c++) begin
        if (runlen <= 0) begin
          cur = ~cur;
          runlen = $urandom_range(maxlen, 1);
        end
        runlen--;
        step(cur, ($urandom_range(511) == 0), ($urandom_range(63) == 0));
      end
      $display("random block %0d: acc=%0d/%0d/%0d rej=%0d/%0d/%0d",
               blk, acc_a, acc_b, acc_c, rej_a, rej_b, rej_c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
